instr_fetch_ctrl: RTL and testbench

Sequencer that drives the 8-entry x 12-bit combinational instruction ROM. It owns the program counter, presents the ROM address, registers the returned word, and hands it to decode over a valid/ready handshake. It supports start, branch redirect, halt and end-of-program detection. It sits between the ROM and the decode/execute stage.

---
 rtl/instr_fetch_pkg.sv | 7 +
 rtl/instr_fetch_ctrl_if.sv | 15 +
 rtl/fetch_out_reg.sv | 40 ++++
 rtl/instr_fetch_ctrl.sv | 93 +++++++++
 tb/tb_instr_fetch_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types and default widths for the instruction fetch sequencer.
package instr_fetch_pkg;
  localparam int ROM_ADDR_W = 3;
  localparam int ROM_DATA_W = 12;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} fetch_state_t;
endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-to-decode instruction handshake (valid/ready).
interface instr_fetch_ctrl_if
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = ROM_DATA_W
);
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instrPc;
  logic              instrValid;
  logic              instrReady;

  modport master (output instr, instrPc, instrValid, input instrReady);
  modport slave  (input instr, instrPc, instrValid, output instrReady);
endinterface

// File: rtl/fetch_out_reg.sv
// Output holding register: captures a fetched word and keeps it until decode takes it.
module fetch_out_reg
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = ROM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              flush,
  input  logic [DATA_W-1:0] load_data,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic              ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              valid,
  output logic              slot_free,
  output logic              accept
);
  assign accept    = valid && ready;
  assign slot_free = !valid || ready;

  // Flush wins over load; otherwise a consumed word simply empties the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr    <= '0;
      instr_pc <= '0;
      valid    <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      instr    <= load_data;
      instr_pc <= load_pc;
      valid    <= 1'b1;
    end else if (accept) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, addresses the ROM and feeds decode.
module instr_fetch_ctrl
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W  = ROM_ADDR_W,
  parameter int DATA_W  = ROM_DATA_W,
  parameter bit WRAP_EN = 1'b0,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    startAddr,
  input  logic                 halt,
  input  logic                 branchValid,
  input  logic [ADDR_W-1:0]    branchTarget,
  output logic [ADDR_W-1:0]    romAddr,
  input  logic [DATA_W-1:0]    romData,
  instr_fetch_ctrl_if.master   dec,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     fetchCount
);
  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic              slot_free;
  logic              accept;
  logic              load;
  logic              flush;

  assign romAddr = pc;
  assign busy    = (state != IDLE);
  assign flush   = (state == RUN) && branchValid;
  assign load    = (state == RUN) && !branchValid && !halt && slot_free;

  fetch_out_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .flush     (flush),
    .load_data (romData),
    .load_pc   (pc),
    .ready     (dec.instrReady),
    .instr     (dec.instr),
    .instr_pc  (dec.instrPc),
    .valid     (dec.instrValid),
    .slot_free (slot_free),
    .accept    (accept)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= '0;
      fetchCount <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept && fetchCount != '1)
        fetchCount <= fetchCount + CNT_W'(1);
      unique case (state)
        IDLE: begin
          if (start) begin
            pc         <= startAddr;
            fetchCount <= '0;
            state      <= RUN;
          end
        end
        RUN: begin
          if (branchValid) begin
            pc <= branchTarget;
          end else if (halt) begin
            state <= DRAIN;
          end else if (slot_free) begin
            pc <= pc + ADDR_W'(1);
            if (!WRAP_EN && pc == '1)
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (slot_free) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Checks a non-wrapping and a wrapping fetch controller side by side against a cycle model.
module tb_instr_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic        branchValid = 1'b0;
  logic        ready = 1'b0;
  logic [2:0]  startAddr = '0;
  logic [2:0]  branchTarget = '0;
  logic [11:0] rom [8];

  logic [2:0]  romAddr0, romAddr1;
  logic [11:0] romData0, romData1;
  logic        busy0, busy1, done0, done1;
  logic [7:0]  cnt0, cnt1;

  instr_fetch_ctrl_if dif0 ();
  instr_fetch_ctrl_if dif1 ();
  assign dif0.instrReady = ready;
  assign dif1.instrReady = ready;
  assign romData0 = rom[romAddr0];
  assign romData1 = rom[romAddr1];

  always #5 clk = ~clk;

  instr_fetch_ctrl #(.ADDR_W(3), .DATA_W(12), .WRAP_EN(1'b0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .startAddr(startAddr), .halt(halt),
    .branchValid(branchValid), .branchTarget(branchTarget), .romAddr(romAddr0),
    .romData(romData0), .dec(dif0), .busy(busy0), .done(done0), .fetchCount(cnt0));

  instr_fetch_ctrl #(.ADDR_W(3), .DATA_W(12), .WRAP_EN(1'b1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .startAddr(startAddr), .halt(halt),
    .branchValid(branchValid), .branchTarget(branchTarget), .romAddr(romAddr1),
    .romData(romData1), .dec(dif1), .busy(busy1), .done(done1), .fetchCount(cnt1));

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: mode 0 = stopped, 1 = fetching, 2 = finishing the last held word.
  int m_mode  [2];
  int m_pc    [2];
  int m_instr [2];
  int m_ipc   [2];
  int m_cnt   [2];
  bit m_valid [2];
  bit m_done  [2];

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      m_mode[w] = 0; m_pc[w] = 0; m_instr[w] = 0; m_ipc[w] = 0;
      m_cnt[w] = 0; m_valid[w] = 0; m_done[w] = 0;
    end
  endtask

  task automatic model_step(input int w, input bit wrap);
    bit taken, room;
    taken = m_valid[w] && ready;
    room  = !m_valid[w] || ready;
    m_done[w] = 0;
    if (taken && m_cnt[w] < 255) m_cnt[w]++;
    case (m_mode[w])
      0: if (start) begin
           m_pc[w] = int'(startAddr); m_cnt[w] = 0; m_mode[w] = 1;
         end
      1: if (branchValid) begin
           m_pc[w] = int'(branchTarget); m_valid[w] = 0;
         end else if (halt) begin
           m_mode[w] = 2;
           if (taken) m_valid[w] = 0;
         end else if (room) begin
           m_instr[w] = int'(rom[m_pc[w]]);
           m_ipc[w]   = m_pc[w];
           m_valid[w] = 1;
           if (m_pc[w] == 7 && !wrap) m_mode[w] = 2;
           m_pc[w] = (m_pc[w] + 1) % 8;
         end
      default: if (room) begin
           m_valid[w] = 0; m_done[w] = 1; m_mode[w] = 0;
         end
    endcase
  endtask

  task automatic check_all();
    check("valid0", dif0.instrValid, m_valid[0]);
    check("instr0", dif0.instr, m_instr[0]);
    check("ipc0",   dif0.instrPc, m_ipc[0]);
    check("addr0",  romAddr0, m_pc[0]);
    check("busy0",  busy0, m_mode[0] != 0);
    check("done0",  done0, m_done[0]);
    check("cnt0",   cnt0, m_cnt[0]);
    check("valid1", dif1.instrValid, m_valid[1]);
    check("instr1", dif1.instr, m_instr[1]);
    check("ipc1",   dif1.instrPc, m_ipc[1]);
    check("addr1",  romAddr1, m_pc[1]);
    check("busy1",  busy1, m_mode[1] != 0);
    check("done1",  done1, m_done[1]);
    check("cnt1",   cnt1, m_cnt[1]);
  endtask

  task automatic cyc(input bit s, input logic [2:0] sa, input bit h,
                     input bit bv, input logic [2:0] bt, input bit r);
    start = s; startAddr = sa; halt = h; branchValid = bv; branchTarget = bt; ready = r;
    model_step(0, 1'b0);
    model_step(1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic settle();
    repeat (3) cyc(1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b1);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
  endtask

  initial begin
    int stall;
    bit r;
    for (int i = 0; i < 8; i++) rom[i] = 12'h100 + 12'(i);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // In-order stream to end of program, then stop the wrapping copy.
    cyc(1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1);
    repeat (11) cyc(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1);
    check("t1_count", cnt0, 8);
    check("t1_busy", busy0, 0);
    check("t5_busy", busy1, 1);
    settle();

    // Backpressure on 0x102 for three cycles.
    cyc(1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1);
    stall = 0;
    for (int k = 0; k < 16; k++) begin
      r = !(m_valid[0] && m_instr[0] == 12'h102 && stall < 3);
      if (!r) stall++;
      cyc(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, r);
    end
    settle();

    // Redirect to 6 while 0x101 is held.
    cyc(1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1);
    stall = 0;
    for (int k = 0; k < 10; k++) begin
      if (stall == 0 && m_valid[0] && m_instr[0] == 12'h101) begin
        stall = 1;
        cyc(1'b0, 3'd0, 1'b0, 1'b1, 3'd6, 1'b0);
      end else begin
        cyc(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1);
      end
    end
    settle();

    // Halt while 0x103 is held.
    cyc(1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1);
    for (int k = 0; k < 8 && !(m_valid[0] && m_instr[0] == 12'h103); k++)
      cyc(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1);
    cyc(1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0);
    repeat (2) cyc(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    repeat (2) cyc(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1);
    check("t4_count", cnt0, 4);
    check("t4_busy", busy0, 0);

    // Wrapping copy from 6, then asynchronous reset mid-run and restart.
    cyc(1'b1, 3'd6, 1'b0, 1'b0, 3'd0, 1'b1);
    repeat (6) cyc(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1);
    async_reset();
    cyc(1'b1, 3'd2, 1'b0, 1'b0, 3'd0, 1'b1);
    repeat (4) cyc(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1);
    settle();

    for (int i = 0; i < 8; i++) rom[i] = 12'($urandom);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 399) == 0) begin
        async_reset();
      end else begin
        cyc($urandom_range(0, 7) == 0, 3'($urandom), $urandom_range(0, 19) == 0,
            $urandom_range(0, 9) == 0, 3'($urandom), $urandom_range(0, 9) < 7);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
